// File: rtl/cnn_frame_feeder_if.sv
// ---------------------------------------------------------------------------
// cnn_frame_feeder_if
//
// Streaming link between the frame feeder and the CNN core.
//
// Signals:
//   start_signal       feeder -> CNN  one-cycle frame-start pulse
//   pixel_valid        feeder -> CNN  qualifies pixel_in
//   pixel_in[7:0]      feeder -> CNN  pixel data, 0 when pixel_valid is low
//   final_result_valid CNN -> feeder  result strobe
//   final_lane_result  CNN -> feeder  signed 48-bit lane result
//
// Modports:
//   master  feeder side
//   slave   CNN side
// ---------------------------------------------------------------------------
interface cnn_frame_feeder_if;
    logic               start_signal;
    logic               pixel_valid;
    logic [7:0]         pixel_in;
    logic               final_result_valid;
    logic signed [47:0] final_lane_result;

    modport master (
        output start_signal,
        output pixel_valid,
        output pixel_in,
        input  final_result_valid,
        input  final_lane_result
    );

    modport slave (
        input  start_signal,
        input  pixel_valid,
        input  pixel_in,
        output final_result_valid,
        output final_lane_result
    );
endinterface

// File: rtl/cnn_frame_feeder.sv
// ---------------------------------------------------------------------------
// cnn_frame_feeder
//
// Holds one image frame written by the host, streams it to a CNN core on
// request and captures the single result the core returns.
//
// Parameters:
//   IMG_PIXELS   pixels per frame (frame buffer depth)
//   TIMEOUT_CYC  cycles to wait for the CNN result before flagging a timeout
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  host frame-buffer write port (dropped while busy)
//   launch              one-cycle request to stream the frame (IDLE only)
//   busy                high from the accepted launch until done
//   done                one-cycle completion pulse
//   timeout_err         result did not arrive within TIMEOUT_CYC cycles
//   result              captured signed 48-bit lane result
//   cnn                 streaming link to the CNN (master side)
//
// Sequence: IDLE -> START (start pulse) -> GAP -> STREAM (IMG_PIXELS beats)
//           -> WAIT (result or timeout) -> FIN (done) -> IDLE.
// ---------------------------------------------------------------------------
module cnn_frame_feeder #(
    parameter int IMG_PIXELS  = 1024,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [9:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                launch,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic signed [47:0]  result,
    cnn_frame_feeder_if.master  cnn
);

    localparam int PW = $clog2(IMG_PIXELS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(IMG_PIXELS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_STREAM,
        ST_WAIT,
        ST_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]      wait_cnt_q, wait_cnt_d;
    logic signed [47:0] result_q, result_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         pixel_q, pixel_d;

    logic [7:0]         frame_mem [IMG_PIXELS];

    // Status and strobes decode straight from the state register.
    assign busy             = (state_q == ST_START) || (state_q == ST_GAP) ||
                              (state_q == ST_STREAM) || (state_q == ST_WAIT);
    assign done             = (state_q == ST_FIN);
    assign timeout_err      = timeout_q;
    assign result           = result_q;
    assign cnn.start_signal = (state_q == ST_START);
    assign cnn.pixel_valid  = (state_q == ST_STREAM);
    assign cnn.pixel_in     = pixel_q;

    // NOTE: the frame buffer has no reset; its contents must survive rst_n,
    // and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            frame_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can infer a latch.
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d   = ST_START;
                    result_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_START: state_d = ST_GAP;
            ST_GAP: begin
                state_d   = ST_STREAM;
                pix_cnt_d = '0;
            end
            ST_STREAM: begin
                if (pix_cnt_q == LAST_PIX) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // A result in the final allowed cycle still wins over timeout;
                // the flag becomes visible TIMEOUT_CYC cycles after entry.
                if (cnn.final_result_valid) begin
                    result_d = cnn.final_lane_result;
                    state_d  = ST_FIN;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Fetch the pixel for the coming cycle so pixel_in is registered and
        // aligned with pixel_valid; zero whenever the stream is not active.
        pixel_d = (state_d == ST_STREAM) ? frame_mem[pix_cnt_d] : 8'h00;
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
            pixel_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            pixel_q    <= pixel_d;
        end
    end

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_cnn_frame_feeder
//
// Directed bench for cnn_frame_feeder with a 100-cycle result timeout.
// Inputs change 1 time unit after the rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_cnn_frame_feeder;

    localparam int IMG_PIXELS  = 1024;
    localparam int TIMEOUT_CYC = 100;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic [9:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               launch;
    logic               busy;
    logic               done;
    logic               timeout_err;
    logic signed [47:0] result;

    cnn_frame_feeder_if cnn_if ();

    cnn_frame_feeder #(
        .IMG_PIXELS  (IMG_PIXELS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .launch      (launch),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .result      (result),
        .cnn         (cnn_if)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_mem [IMG_PIXELS];
    logic [7:0] seen_px5;
    logic [7:0] seen_px7;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy,                0);
        check({tag, "_done"},    done,                0);
        check({tag, "_timeout"}, timeout_err,         0);
        check({tag, "_result"},  result,              0);
        check({tag, "_start"},   cnn_if.start_signal, 0);
        check({tag, "_valid"},   cnn_if.pixel_valid,  0);
        check({tag, "_pixel"},   cnn_if.pixel_in,     0);
    endtask

    // Launches a frame and follows it through START, GAP and STREAM.
    // abort_at >= 0 applies reset while that pixel is on the bus.
    // poke drives launch, a write to address 5 and a result strobe mid-stream.
    // On a normal return the bench sits in the first WAIT cycle.
    task automatic run_stream(input int abort_at, input bit poke);
        int bad;
        bad    = 0;
        launch = 1'b1;
        tick;
        launch = 1'b0;
        wr_en  = 1'b0;
        check("start_pulse",   cnn_if.start_signal, 1);
        check("start_busy",    busy,                1);
        check("start_valid",   cnn_if.pixel_valid,  0);
        check("launch_result", result,              0);
        check("launch_tmo",    timeout_err,         0);
        tick;
        check("gap_start", cnn_if.start_signal, 0);
        check("gap_valid", cnn_if.pixel_valid,  0);
        check("gap_pixel", cnn_if.pixel_in,     0);
        for (int i = 0; i < IMG_PIXELS; i++) begin
            tick;
            if (!cnn_if.pixel_valid || cnn_if.start_signal || cnn_if.pixel_in !== exp_mem[i])
                bad++;
            if (i == 5) seen_px5 = cnn_if.pixel_in;
            if (i == 7) seen_px7 = cnn_if.pixel_in;
            if (i == abort_at) begin
                check("abort_stream_bad", bad, 0);
                #2 rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                return;
            end
            if (poke && i == 300) begin
                launch                   = 1'b1;
                wr_en                    = 1'b1;
                wr_addr                  = 10'd5;
                wr_data                  = 8'hFF;
                cnn_if.final_result_valid = 1'b1;
                cnn_if.final_lane_result  = 48'h0000_0000_0BAD;
            end else if (poke && i == 301) begin
                launch                   = 1'b0;
                wr_en                    = 1'b0;
                cnn_if.final_result_valid = 1'b0;
                cnn_if.final_lane_result  = '0;
            end
        end
        check("stream_bad", bad, 0);
        tick;
        check("wait_valid", cnn_if.pixel_valid, 0);
        check("wait_pixel", cnn_if.pixel_in,    0);
        check("wait_busy",  busy,               1);
        check("wait_done",  done,               0);
    endtask

    // From the first WAIT cycle, the stub returns val `delay` cycles after
    // the last pixel, then done/busy/result are checked and the hold.
    task automatic finish_with_result(input logic [47:0] val, input int delay);
        repeat (delay - 1) tick;
        check("pre_res_done",   done,   0);
        check("pre_res_result", result, 0);
        cnn_if.final_result_valid = 1'b1;
        cnn_if.final_lane_result  = val;
        tick;
        cnn_if.final_result_valid = 1'b0;
        cnn_if.final_lane_result  = '0;
        check("fin_done",    done,        1);
        check("fin_busy",    busy,        0);
        check("fin_result",  result,      val);
        check("fin_timeout", timeout_err, 0);
        tick;
        check("idle_done",   done,   0);
        check("idle_busy",   busy,   0);
        check("hold_result", result, val);
    endtask

    initial begin
        rst_n                    = 1'b0;
        wr_en                    = 1'b0;
        wr_addr                  = '0;
        wr_data                  = '0;
        launch                   = 1'b0;
        cnn_if.final_result_valid = 1'b0;
        cnn_if.final_lane_result  = '0;
        seen_px5                 = '0;
        seen_px7                 = '0;

        repeat (3) tick;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick;

        // Load buffer[i] = i % 256.
        for (int i = 0; i < IMG_PIXELS; i++) begin
            exp_mem[i] = 8'(i);
            wr_en      = 1'b1;
            wr_addr    = 10'(i);
            wr_data    = 8'(i);
            tick;
        end
        wr_en = 1'b0;
        tick;

        // Frame 1: nominal stream, result 40 cycles after the last pixel.
        run_stream(-1, 1'b0);
        finish_with_result(48'd1315356, 40);

        // Frame 2: no result, timeout after 100 cycles in WAIT.
        run_stream(-1, 1'b0);
        repeat (TIMEOUT_CYC - 1) tick;
        check("tmo_early_flag", timeout_err, 0);
        check("tmo_early_done", done,        0);
        check("tmo_early_busy", busy,        1);
        tick;
        check("tmo_flag",   timeout_err, 1);
        check("tmo_done",   done,        1);
        check("tmo_busy",   busy,        0);
        check("tmo_result", result,      0);
        tick;
        check("tmo_hold_flag", timeout_err, 1);
        check("tmo_idle_done", done,        0);

        // Frame 3: launch, write and result strobe during STREAM are ignored.
        run_stream(-1, 1'b1);
        check("poke_px5", seen_px5, 8'h05);
        finish_with_result(48'hA5A5_0000_1234, 5);

        // Reset while idle clears the held result.
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("idle_rst");
        tick;
        rst_n = 1'b1;
        tick;

        // Frame 4: reset at pixel 500.
        run_stream(500, 1'b0);
        check("buf5_kept", seen_px5, 8'h05);
        repeat (2) tick;
        check_all_zero("held_rst");
        rst_n = 1'b1;
        tick;

        // Frame 5: write accepted in the launch cycle, full stream, negative result.
        exp_mem[7] = 8'h77;
        wr_en      = 1'b1;
        wr_addr    = 10'd7;
        wr_data    = 8'h77;
        run_stream(-1, 1'b0);
        check("launch_write", seen_px7, 8'h77);
        finish_with_result(48'hFFFF_FFFF_FFFB, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cnn_frame_feeder.md
CNN_FRAME_FEEDER -- requirements
Module: cnn_frame_feeder

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 1024, pixels per frame (32x32).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, maximum cycles to wait for a result.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, host frame-buffer write strobe.
REQ-006 SHALL have port wr_addr, input, 10, frame-buffer write address.
REQ-007 SHALL have port wr_data, input, 8, frame-buffer write pixel.
REQ-008 SHALL have port launch, input, 1, single-cycle request to stream the frame.
REQ-009 SHALL have port busy, output, 1, high from accepted launch until done.
REQ-010 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port timeout_err, output, 1, result-wait timeout flag.
REQ-012 SHALL have port result, output, 48 signed, captured lane result.
REQ-013 SHALL have port start_signal, output, 1, frame-start pulse to the CNN.
REQ-014 SHALL have port pixel_valid, output, 1, pixel qualifier to the CNN.
REQ-015 SHALL have port pixel_in, output, 8, pixel to the CNN.
REQ-016 SHALL have port final_result_valid, input, 1, CNN result strobe.
REQ-017 SHALL have port final_lane_result, input, 48 signed, CNN result.

Function
REQ-018 SHALL hold an IMG_PIXELS x 8 frame buffer, written on the clk edge when wr_en=1 and busy=0; writes while busy=1 SHALL be dropped.
REQ-019 SHALL implement states IDLE, START, GAP, STREAM, WAIT, FIN.
REQ-020 IDLE: launch=1 SHALL move to START, set busy=1 next cycle, and clear result and timeout_err to 0; launch while busy=1 SHALL be ignored.
REQ-021 START: start_signal=1 for exactly one cycle, then GAP.
REQ-022 GAP: start_signal=0 and pixel_valid=0 for one cycle, then STREAM.
REQ-023 STREAM: pixel_valid=1 for exactly IMG_PIXELS consecutive cycles with pixel_in = buffer[0..IMG_PIXELS-1] in order, with no bubbles; then WAIT.
REQ-024 pixel_in SHALL be registered and SHALL be 0 whenever pixel_valid=0.
REQ-025 In the cycle launch is accepted, a same-cycle wr_en SHALL commit and its data SHALL be streamed.
REQ-026 WAIT: on final_result_valid=1, result SHALL latch final_lane_result (full 48 bits, no truncation), then FIN.
REQ-027 WAIT: counter starts at 0 on entry; if it reaches TIMEOUT_CYC with no final_result_valid, timeout_err SHALL be set, result SHALL stay 0, then FIN.
REQ-028 final_result_valid outside WAIT SHALL be ignored.
REQ-029 FIN: done=1 and busy=0 in that same cycle, then IDLE; result and timeout_err SHALL hold until the next accepted launch.
REQ-030 Launch-to-first-valid-pixel latency SHALL be 3 cycles (launch edge, START, GAP).

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, timeout_err=0, result=0, start_signal=0, pixel_valid=0, pixel_in=0, and clear counters, including mid-stream.
REQ-032 Frame-buffer contents SHALL NOT be cleared by reset.
REQ-033 After rst_n deasserts, the next launch SHALL stream from pixel 0.

Verification
REQ-034 Load buffer[i]=i%256, launch at cycle N -> start_signal high only in cycle N+1; pixel_valid high in cycles N+3..N+1026; pixel_in sequence 0..255 repeated four times.
REQ-035 Stub CNN asserts final_result_valid with 1315356 40 cycles after the last pixel -> result=1315356, done single pulse, busy falls with done, timeout_err=0.
REQ-036 TIMEOUT_CYC=100 with no result -> timeout_err=1 exactly 100 cycles after WAIT entry, done pulses, result=0.
REQ-037 launch and wr_en (addr 5, data 0xFF) asserted during STREAM -> both ignored; stream unchanged; buffer[5] unchanged on the next frame.
REQ-038 rst_n low at pixel 500 -> all outputs 0 asynchronously; relaunch after reset streams pixels 0..1023 with the preserved buffer.
REQ-039 final_result_valid pulsed during STREAM -> not captured; module still waits in WAIT for a later result.
